tfe_hash_gen: RTL
=================

// Module: tfe_hash_gen
// PURPOSE
//  Producer side of the TFE hash stream. Takes key words from the token-feature fetch stage and hashes
//  each one to HASH_W bits in a 2-stage pipeline. Groups are buffered and emitted as o_hash/o_hash_valid
//  bursts for the hash-judging block, with an enforced idle gap between groups.
//  The judging block has no backpressure, so this block owns all output pacing.
// PARAMETERS
//  KEY_W       32  input key width; fixed at 32 in this revision
//  HASH_W      16  output hash width; fixed at 16 in this revision
//  FIFO_DEPTH  8   output FIFO entries, power of 2, >=4
//  GAP_CYC     4   idle cycles forced after each group's last hash, >=1
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous reset, active-high
//  i_key          in   KEY_W   key word
//  i_key_valid    in   1       key word present
//  i_key_last     in   1       key is last of its group
//  o_key_ready    out  1       key accepted when valid&&ready
//  i_out_stall    in   1       hold output; tie 0 when driving the judging block
//  o_hash         out  HASH_W  hash value
//  o_hash_valid   out  1       one hash per cycle while high
//  o_hash_last    out  1       qualifies last hash of group
//  o_group_done   out  1       1-cycle pulse, cycle after o_hash_last beat
//  o_group_cnt    out  16      hashes emitted in current/last group
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; pipeline cleared; FSM=IDLE. Reset mid-burst drops all in-flight data.
//  Hash function, all arithmetic truncated to 16 bits:
//    s1 = key[31:16]^key[15:0]
//    p  = (s1*16'h9E37) mod 2^16
//    hash = p^(p>>8)
//  Pipeline: S1 registers s1 and last; S2 registers hash and last, then writes to FIFO.
//    No stall inside the pipeline.
//  Credit rule: o_key_ready = (fifo_count + pipe_occupancy) < FIFO_DEPTH, registered-safe.
//    The FIFO can never overflow. No ready-to-valid combinational dependency.
//  Latency: key accepted at cycle t reaches the FIFO at t+2.
//    In IDLE/SEND with an empty FIFO, o_hash_valid is high at t+3 (registered output).
//  FSM:
//    IDLE: FIFO non-empty && !i_out_stall -> pop, go to SEND.
//    SEND: pop each cycle FIFO non-empty && !stall.
//      - FIFO empty mid-group: o_hash_valid=0 bubble, stay in SEND.
//      - Popped entry has last: drive o_hash_last, go to GAP.
//    GAP: no pops for GAP_CYC cycles, then IDLE. Keys keep being accepted during GAP.
//  Stall: i_out_stall=1 blocks the pop. o_hash_valid=0 next cycle; o_hash holds its last value.
//  o_group_cnt: set to 1 on the first beat of a group, +1 per beat, held through GAP.
//    Saturates at 16'hFFFF.
//  Simultaneous FIFO push and pop when full or empty:
//    - Push when full never occurs (credit rule).
//    - Pop on the same cycle as a push into an empty FIFO is not allowed. Data becomes poppable one cycle after the write.
//  Back-to-back single-key groups each still incur the full GAP.
//  Assertions: no FIFO overflow/underflow; o_hash_last implies o_hash_valid.
// STRUCTURE
//  tfe_pkg: HASH_MULT=16'h9E37; FSM state enum {IDLE,SEND,GAP}; typedef hash_entry_t {last, hash[15:0]}.
//  Sub-module tfe_hash_fifo: sync FIFO with count output (width HASH_W+1, depth FIFO_DEPTH).
//  Hash pipeline and FSM live in the top module.
// TESTING
//  1. Keys 0x0,0x1,0x2,0x00010001 (last on 4th) -> hashes 0x0000,0x9EA9,0x3C52,0x0000;
//     o_hash_last on 4th beat; o_group_cnt=4; o_group_done next cycle.
//  2. Single key 0x1 in idle block -> o_hash_valid high exactly 3 cycles after acceptance.
//  3. Two groups of 10 back-to-back (keys 10..19, 0..9) -> exactly GAP_CYC=4 idle cycles
//     between the two o_hash_last/first beats.
//  4. Hold i_out_stall=1, stream 20 keys -> o_key_ready drops after 8 accepted;
//     release stall -> all 20 out in order, no loss or dup.
//  5. Keys with i_key_valid toggling every other cycle -> bubbles on output, FSM stays SEND,
//     o_group_cnt counts only valid beats.
//  6. Assert rst while 5 keys are in flight -> all outputs 0 next cycle;
//     a post-reset group emits only its own hashes.

Source files
------------

// File: rtl/tfe_pkg.sv
// Shared types and hash helper for the TFE hash stream producer.
package tfe_pkg;

    localparam logic [15:0] HASH_MULT = 16'h9E37;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    typedef struct packed {
        logic        last;
        logic [15:0] hash;
    } hash_entry_t;

    function automatic logic [15:0] tfe_hash(input logic [15:0] s1);
        logic [15:0] p;
        p = s1 * HASH_MULT;
        return p ^ (p >> 8);
    endfunction

endpackage

// File: rtl/tfe_hash_fifo.sv
// Synchronous FIFO with occupancy count; read data is the current head entry.
module tfe_hash_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !rd_en && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_en && count == '0));
`endif

endmodule

// File: rtl/tfe_hash_gen.sv
// TFE hash producer: hashes key words, buffers them and emits paced groups.
//   state | meaning
//   IDLE  | waiting for the first entry of a group
//   SEND  | popping one entry per cycle until the group's last entry
//   GAP   | forced idle for GAP_CYC cycles after a group
module tfe_hash_gen
    import tfe_pkg::*;
#(
    parameter int KEY_W      = 32,
    parameter int HASH_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYC    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  i_key,
    input  logic              i_key_valid,
    input  logic              i_key_last,
    output logic              o_key_ready,
    input  logic              i_out_stall,
    output logic [HASH_W-1:0] o_hash,
    output logic              o_hash_valid,
    output logic              o_hash_last,
    output logic              o_group_done,
    output logic [15:0]       o_group_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(GAP_CYC) + 1;

    logic        accept;
    logic        s1_valid;
    logic        s1_last;
    logic [15:0] s1_val;

    hash_entry_t        wr_entry;
    hash_entry_t        rd_entry;
    logic [HASH_W:0]    rd_raw;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      count_next;

    state_t        state, state_next;
    logic [GW-1:0] gap_cnt, gap_next;
    logic          pop;

    assign accept = i_key_valid && o_key_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_val   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_val  <= i_key[31:16] ^ i_key[15:0];
                s1_last <= i_key_last;
            end
        end
    end

    // The second pipeline register is the FIFO entry itself, so a hash is
    // poppable the cycle after it is written.
    assign wr_entry.last = s1_last;
    assign wr_entry.hash = tfe_hash(s1_val);

    tfe_hash_fifo #(
        .W     (HASH_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s1_valid),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_raw),
        .count   (fifo_count)
    );

    assign rd_entry = hash_entry_t'(rd_raw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
        end
    end

    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        pop        = 1'b0;
        case (state)
            IDLE, SEND: begin
                if (fifo_count != '0 && !i_out_stall) begin
                    pop = 1'b1;
                    if (rd_entry.last) begin
                        state_next = GAP;
                        gap_next   = GW'(GAP_CYC - 1);
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Credit counts the entry in S1 plus the FIFO, looking one cycle ahead.
    assign count_next = fifo_count + CW'(s1_valid) - CW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_key_ready  <= 1'b0;
            o_hash       <= '0;
            o_hash_valid <= 1'b0;
            o_hash_last  <= 1'b0;
            o_group_done <= 1'b0;
            o_group_cnt  <= '0;
        end else begin
            o_key_ready  <= ({1'b0, count_next} + (CW+1)'(accept)) < (CW+1)'(FIFO_DEPTH);
            o_hash_valid <= pop;
            o_hash_last  <= pop && rd_entry.last;
            o_group_done <= o_hash_last;
            if (pop) begin
                o_hash <= rd_entry.hash;
                if (state == IDLE) begin
                    o_group_cnt <= 16'd1;
                end else if (o_group_cnt != 16'hFFFF) begin
                    o_group_cnt <= o_group_cnt + 16'd1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_last_has_valid: assert property (@(posedge clk) disable iff (rst)
        o_hash_last |-> o_hash_valid);
`endif

endmodule
